dm9000a_tx_drain: RTL and testbench
===================================

# dm9000a_tx_drain

Transmit-side bus engine for the DM9000A Ethernet controller. Once a frame has been packed into the 8-to-16-bit Tx FIFO, this block does the rest of the transmit sequence in the `iDm9000aClk` domain:
- programs the frame length;
- streams the 16-bit FIFO words into the DM9000A Tx SRAM;
- issues TXREQ and polls for completion.

It sits between the Tx FIFO read port and the shared DM9000A host bus, and requests that bus from the bus arbiter, which is also used by the Rx path.

## Interface
- `P_IOW_LOW`, default 2: clocks that `iow_n`/`ior_n` are held low per bus cycle, range 1..7.
- `P_POLL_MAX`, default 1023: maximum TCR status reads before a timeout is declared.
- `iDm9000aClk`, in, 1: the block's only clock; all logic is rising-edge.
- `iRst_n`, in, 1: asynchronous active-low reset.
- `in_from_Task_start`, in, 1: one-clock pulse that starts a frame transmit.
- `in_from_Task_len`, in, 11: frame length in bytes, sampled on start.
- `in_from_Arbiter_grant`, in, 1: bus granted to this block.
- `out_to_Arbiter_req`, out, 1: bus request.
- `in_from_Fifo_rdempty`, in, 1: Tx FIFO empty flag.
- `in_from_Fifo_q`, in, 16: Tx FIFO data. Valid the clock after `rdreq` (non-showahead). The first frame byte is on `[7:0]`.
- `out_to_Fifo_rdreq`, out, 1: FIFO read strobe.
- `out_to_Dm9000a_cs_n`, out, 1: DM9000A chip select.
- `out_to_Dm9000a_cmd`, out, 1: DM9000A CMD pin (0 = index, 1 = data).
- `out_to_Dm9000a_iow_n`, out, 1: write strobe.
- `out_to_Dm9000a_ior_n`, out, 1: read strobe.
- `out_to_Dm9000a_sd`, out, 16: write data.
- `out_to_Dm9000a_sd_oe`, out, 1: SD output enable.
- `in_from_Dm9000a_sd`, in, 16: read data.
- `out_busy`, out, 1: high from an accepted start until done.
- `out_done`, out, 1: one-clock pulse at the end of every accepted transmit.
- `out_error`, out, 1: poll timeout flag. Valid with `out_done` and held until the next accepted start.

## Operation

**Start and length handling**
- A start is accepted only in IDLE and only with len ≠ 0. Starts with len = 0, or any start while busy, are ignored: no request, no done.
- On an accepted start: latch len, compute words = (len+1)>>1 (12-bit arithmetic, no overflow), clear `out_error`, raise `out_busy` and `out_to_Arbiter_req`.

**State sequence**
- IDLE → WAIT_GNT → TXPLL_IX → TXPLL_D → TXPLH_IX → TXPLH_D → MWCMD_IX → FETCH ↔ DWR → TCR_IX → TCR_D → POLL_IX → POLL_RD → DONE → IDLE.

**Bus writes, in order**
- Register writes:
  - Index 0x00FC, then data {8'h00, len[7:0]}.
  - Index 0x00FD, then data {13'h0, len[10:8]}.
  - Index 0x00F8.
- Data phase:
  - One data write per FIFO word, for `words` words.
  - The word goes out unmodified. For odd len the upper byte of the last word is don't-care; the DM9000A trims by TXPL.
- After the data phase: index 0x0002, then data 0x0001 (TXREQ).

**FETCH / DWR data phase**
- In FETCH, `rdreq` is pulsed for one clock only when `rdempty` = 0.
- If the FIFO is empty, FETCH waits indefinitely with the bus idle (cs_n = 1) and `req` still held.
- The word is captured the clock after `rdreq`. DWR then performs one write cycle.
- Word counter decrements per DWR. When it reaches 0, go to TCR_IX.

**Status poll**
- POLL_IX writes index 0x0002.
- POLL_RD performs read cycles until `sd[0]` = 0, then goes to DONE.
- After P_POLL_MAX reads with `sd[0]` = 1, set `out_error` and go to DONE.

**DONE**
- `out_done` = 1 for one clock.
- `out_busy` and `req` drop on the following clock.

**Grant handling**
- Grant is checked only in WAIT_GNT. Once granted, the bus is held until DONE.

**Reset**
- `iRst_n` low at any time, including mid-frame, forces IDLE immediately. No further `rdreq` is issued.
- Reset values:
  - `cs_n`, `iow_n`, `ior_n` = 1.
  - `cmd`, `sd_oe`, `rdreq`, `req`, `busy`, `done`, `error` = 0.
  - `sd` = 0.

## Timing

**Write cycle: 2 + P_IOW_LOW clocks, all outputs registered**
- T1: cs_n = 0, cmd and sd valid, sd_oe = 1, iow_n = 1.
- T2 .. T(1+P_IOW_LOW): iow_n = 0.
- Last clock: iow_n = 1, cs_n = 1, sd and sd_oe still held.

**Read cycle: same shape as the write cycle, with these differences**
- sd_oe = 0 and `ior_n` is the strobe.
- `in_from_Dm9000a_sd` is sampled on the last clock ior_n = 0.

**Latencies**
- Start → req: 1 clock.
- Grant seen → first T1: 1 clock.
- FETCH → DWR T1, FIFO non-empty: 2 clocks.
- Per-word cost without stalls: 2 + (2 + P_IOW_LOW) = 6 clocks at default.

**Ordering**
- No two bus cycles overlap.
- cs_n is high for at least one clock between cycles.

## Test plan
- **len = 60, FIFO pre-filled with 30 words, grant tied high.** SD write sequence: 0x00FC, 0x003C, 0x00FD, 0x0000, 0x00F8, 30 data words in order, 0x0002, 0x0001. Exactly 30 `rdreq` pulses. First poll read returns 0 → one `done` pulse, error = 0.
- **len = 61.** 31 words written; TXPLH data 0x0000, TXPLL data 0x003D.
- **len = 1514, FIFO emptied for 20 clocks mid-frame.** Bus idle during the stall (cs_n = 1). All 757 words delivered, nothing duplicated or dropped.
- **Poll always returns bit0 = 1, P_POLL_MAX = 4.** Exactly 4 read cycles, then `done` with error = 1.
- **Start with len = 0, and a second start while busy.** No `req`, no extra `done`; the in-progress frame completes normally.
- **iRst_n low during the data phase.** All bus outputs return to their idle values asynchronously. A new start after release runs the full sequence from 0x00FC.

Source files
------------

// File: rtl/dm9000a_tx_drain.sv
// Transmit bus engine for the DM9000A: programs TXPL, streams Tx FIFO words into
// the chip SRAM, issues TXREQ and polls TCR until the frame has left.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for a start with non-zero length
// WAIT_GNT    | bus requested, waiting for the arbiter grant
// TXPLL_IX/_D | index 0xFC, then low length byte
// TXPLH_IX/_D | index 0xFD, then high length bits
// MWCMD_IX    | index 0xF8, opens the SRAM write window
// FETCH       | pulse rdreq when the FIFO has data, wait one clock for q
// DWR         | one data write per FIFO word
// TCR_IX/_D   | index 0x02, then TXREQ
// POLL_IX     | index 0x02 ahead of the status reads
// POLL_RD     | read TCR until TXREQ clears or the poll budget runs out
// DONE        | one-clock done pulse, busy/req drop on the next clock
module dm9000a_tx_drain #(
    parameter int P_IOW_LOW  = 2,
    parameter int P_POLL_MAX = 1023
) (
    input  logic        iDm9000aClk,
    input  logic        iRst_n,
    input  logic        in_from_Task_start,
    input  logic [10:0] in_from_Task_len,
    input  logic        in_from_Arbiter_grant,
    output logic        out_to_Arbiter_req,
    input  logic        in_from_Fifo_rdempty,
    input  logic [15:0] in_from_Fifo_q,
    output logic        out_to_Fifo_rdreq,
    output logic        out_to_Dm9000a_cs_n,
    output logic        out_to_Dm9000a_cmd,
    output logic        out_to_Dm9000a_iow_n,
    output logic        out_to_Dm9000a_ior_n,
    output logic [15:0] out_to_Dm9000a_sd,
    output logic        out_to_Dm9000a_sd_oe,
    input  logic [15:0] in_from_Dm9000a_sd,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_error
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT_GNT, ST_TXPLL_IX, ST_TXPLL_D, ST_TXPLH_IX, ST_TXPLH_D,
        ST_MWCMD_IX, ST_FETCH, ST_DWR, ST_TCR_IX, ST_TCR_D, ST_POLL_IX,
        ST_POLL_RD, ST_DONE
    } state_t;

    localparam logic [3:0]    TMR_LOAD  = 4'(P_IOW_LOW + 1);
    localparam int            PW        = $clog2(P_POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LOAD = PW'(P_POLL_MAX);

    state_t        state;
    logic [10:0]   len_q;
    logic [10:0]   word_cnt;
    logic [3:0]    tmr;
    logic [PW-1:0] poll_cnt;
    logic          poll_bit;
    logic          data_pend;

    logic [11:0]   words_calc;
    logic          bus_st;
    logic          launch;
    state_t        go_st;
    logic          go_cmd;
    logic [15:0]   go_sd;
    logic          go_err;
    logic          unused_bits;

    assign words_calc  = ({1'b0, in_from_Task_len} + 12'd1) >> 1;
    assign unused_bits = &{1'b0, in_from_Dm9000a_sd[15:1], words_calc[11]};

    assign bus_st = state inside {ST_TXPLL_IX, ST_TXPLL_D, ST_TXPLH_IX, ST_TXPLH_D,
                                  ST_MWCMD_IX, ST_DWR, ST_TCR_IX, ST_TCR_D,
                                  ST_POLL_IX, ST_POLL_RD};

    // A new step starts when a bus cycle finishes, the grant arrives, or fetched data is ready.
    assign launch = (state == ST_WAIT_GNT && in_from_Arbiter_grant) ||
                    (state == ST_FETCH && data_pend) ||
                    (bus_st && tmr == 4'd0);

    always_comb begin
        go_st  = state;
        go_cmd = 1'b0;
        go_sd  = 16'h0000;
        go_err = 1'b0;
        case (state)
            ST_WAIT_GNT: begin go_st = ST_TXPLL_IX; go_sd = 16'h00FC; end
            ST_TXPLL_IX: begin go_st = ST_TXPLL_D; go_cmd = 1'b1; go_sd = {8'h00, len_q[7:0]}; end
            ST_TXPLL_D:  begin go_st = ST_TXPLH_IX; go_sd = 16'h00FD; end
            ST_TXPLH_IX: begin go_st = ST_TXPLH_D; go_cmd = 1'b1; go_sd = {13'h0000, len_q[10:8]}; end
            ST_TXPLH_D:  begin go_st = ST_MWCMD_IX; go_sd = 16'h00F8; end
            ST_MWCMD_IX: go_st = ST_FETCH;
            ST_FETCH:    begin go_st = ST_DWR; go_cmd = 1'b1; go_sd = in_from_Fifo_q; end
            ST_DWR: begin
                if (word_cnt == 11'd1) begin
                    go_st = ST_TCR_IX;
                    go_sd = 16'h0002;
                end else begin
                    go_st = ST_FETCH;
                end
            end
            ST_TCR_IX:   begin go_st = ST_TCR_D; go_cmd = 1'b1; go_sd = 16'h0001; end
            ST_TCR_D:    begin go_st = ST_POLL_IX; go_sd = 16'h0002; end
            ST_POLL_IX:  begin go_st = ST_POLL_RD; go_cmd = 1'b1; end
            ST_POLL_RD: begin
                go_cmd = 1'b1;
                if (!poll_bit) begin
                    go_st = ST_DONE;
                end else if (poll_cnt == PW'(1)) begin
                    go_st  = ST_DONE;
                    go_err = 1'b1;
                end else begin
                    go_st = ST_POLL_RD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state                <= ST_IDLE;
            len_q                <= '0;
            word_cnt             <= '0;
            tmr                  <= '0;
            poll_cnt             <= '0;
            poll_bit             <= 1'b0;
            data_pend            <= 1'b0;
            out_to_Arbiter_req   <= 1'b0;
            out_to_Fifo_rdreq    <= 1'b0;
            out_to_Dm9000a_cs_n  <= 1'b1;
            out_to_Dm9000a_cmd   <= 1'b0;
            out_to_Dm9000a_iow_n <= 1'b1;
            out_to_Dm9000a_ior_n <= 1'b1;
            out_to_Dm9000a_sd    <= '0;
            out_to_Dm9000a_sd_oe <= 1'b0;
            out_busy             <= 1'b0;
            out_done             <= 1'b0;
            out_error            <= 1'b0;
        end else begin
            out_done <= 1'b0;
            if (launch) begin
                state     <= go_st;
                data_pend <= 1'b0;
                if (state == ST_DWR)
                    word_cnt <= word_cnt - 11'd1;
                if (go_st == ST_FETCH) begin
                    out_to_Fifo_rdreq    <= !in_from_Fifo_rdempty;
                    out_to_Dm9000a_cmd   <= 1'b0;
                    out_to_Dm9000a_sd_oe <= 1'b0;
                end else if (go_st == ST_DONE) begin
                    out_done             <= 1'b1;
                    out_error            <= go_err;
                    out_to_Dm9000a_cmd   <= 1'b0;
                    out_to_Dm9000a_sd_oe <= 1'b0;
                end else begin
                    out_to_Dm9000a_cs_n  <= 1'b0;
                    out_to_Dm9000a_cmd   <= go_cmd;
                    out_to_Dm9000a_sd_oe <= (go_st != ST_POLL_RD);
                    tmr                  <= TMR_LOAD;
                    if (go_st != ST_POLL_RD)
                        out_to_Dm9000a_sd <= go_sd;
                    if (state == ST_POLL_IX)
                        poll_cnt <= POLL_LOAD;
                    else if (state == ST_POLL_RD)
                        poll_cnt <= poll_cnt - PW'(1);
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_from_Task_start && in_from_Task_len != 11'd0) begin
                            len_q              <= in_from_Task_len;
                            word_cnt           <= words_calc[10:0];
                            out_error          <= 1'b0;
                            out_busy           <= 1'b1;
                            out_to_Arbiter_req <= 1'b1;
                            state              <= ST_WAIT_GNT;
                        end
                    end
                    ST_FETCH: begin
                        if (out_to_Fifo_rdreq) begin
                            out_to_Fifo_rdreq <= 1'b0;
                            data_pend         <= 1'b1;
                        end else if (!in_from_Fifo_rdempty) begin
                            out_to_Fifo_rdreq <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        out_busy           <= 1'b0;
                        out_to_Arbiter_req <= 1'b0;
                        state              <= ST_IDLE;
                    end
                    default: begin
                        if (bus_st) begin
                            if (tmr == TMR_LOAD) begin
                                if (state == ST_POLL_RD)
                                    out_to_Dm9000a_ior_n <= 1'b0;
                                else
                                    out_to_Dm9000a_iow_n <= 1'b0;
                            end else if (tmr == 4'd1) begin
                                out_to_Dm9000a_iow_n <= 1'b1;
                                out_to_Dm9000a_ior_n <= 1'b1;
                                out_to_Dm9000a_cs_n  <= 1'b1;
                                if (state == ST_POLL_RD)
                                    poll_bit <= in_from_Dm9000a_sd[0];
                            end
                            tmr <= tmr - 4'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dm9000a_tx_drain.sv
// Scoreboard bench for dm9000a_tx_drain: expected bus cycles are queued by the
// stimulus and popped by a monitor at the start of every DUT bus cycle.
module tb_dm9000a_tx_drain;

    localparam int IOW     = 2;
    localparam int POLLMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic        grant = 1'b1;
    logic        req;
    logic        rdempty;
    logic [15:0] fifo_q = '0;
    logic        rdreq;
    logic        cs_n, cmd, iow_n, ior_n, sd_oe;
    logic [15:0] sd;
    logic        poll_v = 1'b0;
    logic [15:0] rd_sd;
    logic        busy, done, error;

    always #5 clk = ~clk;
    assign rd_sd = {15'h0000, poll_v};

    dm9000a_tx_drain #(.P_IOW_LOW(IOW), .P_POLL_MAX(POLLMAX)) dut (
        .iDm9000aClk(clk), .iRst_n(rst_n),
        .in_from_Task_start(start), .in_from_Task_len(len),
        .in_from_Arbiter_grant(grant), .out_to_Arbiter_req(req),
        .in_from_Fifo_rdempty(rdempty), .in_from_Fifo_q(fifo_q), .out_to_Fifo_rdreq(rdreq),
        .out_to_Dm9000a_cs_n(cs_n), .out_to_Dm9000a_cmd(cmd),
        .out_to_Dm9000a_iow_n(iow_n), .out_to_Dm9000a_ior_n(ior_n),
        .out_to_Dm9000a_sd(sd), .out_to_Dm9000a_sd_oe(sd_oe),
        .in_from_Dm9000a_sd(rd_sd),
        .out_busy(busy), .out_done(done), .out_error(error)
    );

    typedef struct packed {
        logic        rd;
        logic        cmd;
        logic [15:0] sd;
    } bus_t;

    bus_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Non-showahead FIFO model: q updates on the edge that samples rdreq.
    logic [15:0] mem [0:4095];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   rd_cnt = 0;
    logic stall = 1'b0;
    logic fifo_clr = 1'b0;

    assign rdempty = stall || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (rdreq) begin
            check("rdreq_nonempty", {31'h0, rdempty}, 32'h0);
            fifo_q <= mem[rd_ptr[11:0]];
            rd_ptr <= rd_ptr + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Bus monitor
    int   done_cnt = 0;
    logic last_err = 1'b0;
    logic in_cyc = 1'b0;
    logic cur_rd = 1'b0;
    logic done_prev = 1'b0;
    int   strb = 0;
    bus_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_cyc    = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (done_prev)
                check("busy_req_drop_after_done", {30'h0, busy, req}, 32'h0);
            done_prev = done;
            if (done) begin
                done_cnt++;
                last_err = error;
            end
            if (!in_cyc && !cs_n) begin
                in_cyc = 1'b1;
                strb   = 0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_cycle: got cmd=%0d sd=0x%0h sd_oe=%0d, expected no cycle", cmd, sd, sd_oe);
                    cur_rd = !sd_oe;
                end else begin
                    e = exp_q.pop_front();
                    cur_rd = e.rd;
                    check("cyc_dir", {31'h0, !sd_oe}, {31'h0, e.rd});
                    check("cyc_cmd", {31'h0, cmd}, {31'h0, e.cmd});
                    if (!e.rd)
                        check("cyc_sd", {16'h0, sd}, {16'h0, e.sd});
                    check("cyc_t1_strobes", {30'h0, iow_n, ior_n}, 32'h3);
                end
            end else if (in_cyc) begin
                if (cur_rd ? !ior_n : !iow_n) strb++;
                if (cur_rd ? !iow_n : !ior_n) strb += 100;
                if (cs_n) begin
                    in_cyc = 1'b0;
                    check("strobe_width", strb, IOW);
                end
            end
        end
    end

    task automatic exp_w(input logic c, input logic [15:0] d);
        exp_q.push_back('{rd: 1'b0, cmd: c, sd: d});
    endtask

    task automatic exp_hdr(input logic [15:0] lo, input logic [15:0] hi);
        exp_w(1'b0, 16'h00FC); exp_w(1'b1, lo);
        exp_w(1'b0, 16'h00FD); exp_w(1'b1, hi);
        exp_w(1'b0, 16'h00F8);
    endtask

    task automatic exp_tail(input int nrd);
        exp_w(1'b0, 16'h0002); exp_w(1'b1, 16'h0001);
        exp_w(1'b0, 16'h0002);
        for (int i = 0; i < nrd; i++) exp_q.push_back('{rd: 1'b1, cmd: 1'b1, sd: 16'h0000});
    endtask

    task automatic load_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[11:0]] = base + 16'(i);
            wr_ptr++;
            exp_w(1'b1, base + 16'(i));
        end
    endtask

    task automatic start_frame(input logic [10:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
    endtask

    localparam logic [25:0] IDLE_VEC = {3'b111, 7'b0000000, 16'h0000};

    initial begin
        int d0, r0, cs_low;
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'h0, cs_n, iow_n, ior_n, cmd, sd_oe, rdreq, req, busy, done, error, sd},
              {6'h0, IDLE_VEC});
        rst_n = 1'b1;
        @(negedge clk);

        // len 60, grant held off for a few clocks
        grant = 1'b0;
        exp_hdr(16'h003C, 16'h0000); load_words(16'h1000, 30); exp_tail(1);
        d0 = done_cnt; r0 = rd_cnt;
        start_frame(11'd60);
        check("req_one_clock_after_start", {31'h0, req}, 32'h1);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        cs_low = 0;
        repeat (5) begin @(negedge clk); if (!cs_n) cs_low++; end
        check("bus_idle_without_grant", cs_low, 0);
        grant = 1'b1;
        wait_done(d0, 2000);
        check("rdreq_count_len60", rd_cnt - r0, 30);
        check("error_len60", {31'h0, last_err}, 32'h0);

        // len 61: odd length, one extra word
        exp_hdr(16'h003D, 16'h0000); load_words(16'h2000, 31); exp_tail(1);
        d0 = done_cnt; r0 = rd_cnt;
        start_frame(11'd61);
        wait_done(d0, 2000);
        check("rdreq_count_len61", rd_cnt - r0, 31);
        check("error_len61", {31'h0, last_err}, 32'h0);

        // len 1514 with a 20-clock FIFO stall
        exp_hdr(16'h00EA, 16'h0005); load_words(16'h4000, 757); exp_tail(1);
        d0 = done_cnt; r0 = rd_cnt;
        start_frame(11'd1514);
        for (int k = 0; k < 5000 && (rd_cnt - r0) < 300; k++) @(negedge clk);
        check("stall_point_reached", {31'h0, (rd_cnt - r0) >= 300}, 32'h1);
        stall = 1'b1;
        cs_low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 7 && !cs_n) cs_low++;
        end
        check("bus_idle_during_stall", cs_low, 0);
        check("req_held_during_stall", {31'h0, req}, 32'h1);
        stall = 1'b0;
        wait_done(d0, 10000);
        check("rdreq_count_len1514", rd_cnt - r0, 757);
        check("error_len1514", {31'h0, last_err}, 32'h0);

        // Poll never clears: exactly POLLMAX reads then error
        poll_v = 1'b1;
        exp_hdr(16'h0002, 16'h0000); load_words(16'h5A5A, 1); exp_tail(4);
        d0 = done_cnt;
        start_frame(11'd2);
        wait_done(d0, 2000);
        check("error_on_timeout", {31'h0, last_err}, 32'h1);
        repeat (3) @(negedge clk);
        check("error_held", {31'h0, error}, 32'h1);
        poll_v = 1'b0;

        // Zero-length start is ignored
        d0 = done_cnt;
        start_frame(11'd0);
        check("req_len0", {31'h0, req}, 32'h0);
        repeat (10) @(negedge clk);
        check("busy_len0", {31'h0, busy}, 32'h0);
        check("done_len0", done_cnt - d0, 0);
        check("error_kept_after_len0", {31'h0, error}, 32'h1);

        // Second start while busy is ignored
        exp_hdr(16'h0004, 16'h0000); load_words(16'h6000, 2); exp_tail(1);
        r0 = rd_cnt;
        start_frame(11'd4);
        check("error_cleared_on_start", {31'h0, error}, 32'h0);
        repeat (3) @(negedge clk);
        start_frame(11'd10);
        wait_done(d0, 2000);
        check("rdreq_count_len4", rd_cnt - r0, 2);
        repeat (40) @(negedge clk);
        check("no_extra_done", done_cnt - d0, 1);
        check("no_req_after_ignored_start", {31'h0, req}, 32'h0);

        // Reset in the data phase
        exp_hdr(16'h003C, 16'h0000); load_words(16'h7000, 30); exp_tail(1);
        r0 = rd_cnt;
        start_frame(11'd60);
        for (int k = 0; k < 2000 && (rd_cnt - r0) < 10; k++) @(negedge clk);
        check("reset_point_reached", {31'h0, (rd_cnt - r0) >= 10}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {6'h0, cs_n, iow_n, ior_n, cmd, sd_oe, rdreq, req, busy, done, error, sd},
              {6'h0, IDLE_VEC});
        exp_q.delete();
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        r0 = rd_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_rdreq_after_reset", rd_cnt - r0, 0);
        check("req_low_after_reset", {31'h0, req}, 32'h0);
        exp_hdr(16'h0004, 16'h0000); load_words(16'h7100, 2); exp_tail(1);
        d0 = done_cnt; r0 = rd_cnt;
        start_frame(11'd4);
        wait_done(d0, 2000);
        check("rdreq_count_after_reset", rd_cnt - r0, 2);
        check("error_after_reset_frame", {31'h0, last_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
